// File: rtl/cpu_mem_responder.sv
// Memory-side responder for the CPU: a single-port word memory serving one fetch plus an
// optional load/store per transaction, with a memory-mapped countdown timer driving irq.
module cpu_mem_responder #(
  parameter int          ADDR_WIDTH = 10,
  parameter int          INST_WAIT  = 0,
  parameter int          DATA_WAIT  = 0,
  parameter logic [31:0] IRQ_ADDR   = 32'hFFFF_FFF0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] inst_addr,
  output logic [31:0] inst_data,
  input  logic        data_req,
  input  logic        data_we,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_out,
  output logic [31:0] data_in,
  output logic        halt,
  output logic        irq
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {
    ST_ACCEPT = 2'd0,
    ST_DATA   = 2'd1,
    ST_INST   = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t                  state_r;
  logic [3:0]              cnt_r;
  logic [ADDR_WIDTH-1:0]   inst_idx_r;
  logic [ADDR_WIDTH-1:0]   data_idx_r;
  logic                    data_we_r;
  logic                    irq_hit_r;
  logic [31:0]             wdata_r;
  logic [15:0]             tcnt_r;
  logic [31:0]             inst_data_r;
  logic [31:0]             data_in_r;
  logic                    irq_r;
  logic                    mem_we_s;
  logic [31:0]             mem_r [DEPTH];

  // Address bits outside the word index are deliberately ignored (aliasing).
  logic unused_addr_bits_s;
  assign unused_addr_bits_s = ^{inst_addr[1:0], inst_addr[31:ADDR_WIDTH+2],
                                data_addr[1:0], data_addr[31:ADDR_WIDTH+2]};

  // Memory write strobe: store completing in DATA that does not target the timer register
  always_comb begin
    mem_we_s = 1'b0;
    if ((state_r == ST_DATA) && (cnt_r == 4'd0) && data_we_r && !irq_hit_r) begin
      mem_we_s = 1'b1;
    end else begin
      mem_we_s = 1'b0;
    end
  end

  // Memory array write port; contents are intentionally not reset
  always_ff @(posedge clock) begin
    if (mem_we_s) begin
      mem_r[data_idx_r] <= wdata_r;
    end
  end

  // Transaction sequencer, read datapath and interrupt timer
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_ACCEPT;
      cnt_r       <= 4'd0;
      inst_idx_r  <= '0;
      data_idx_r  <= '0;
      data_we_r   <= 1'b0;
      irq_hit_r   <= 1'b0;
      wdata_r     <= 32'd0;
      tcnt_r      <= 16'd0;
      inst_data_r <= 32'd0;
      data_in_r   <= 32'd0;
      irq_r       <= 1'b0;
    end else begin
      case (state_r)
        ST_ACCEPT: begin
          inst_idx_r <= inst_addr[ADDR_WIDTH+1:2];
          data_idx_r <= data_addr[ADDR_WIDTH+1:2];
          data_we_r  <= data_we;
          irq_hit_r  <= (data_addr == IRQ_ADDR);
          wdata_r    <= data_out;
          if (data_req) begin
            state_r <= ST_DATA;
            cnt_r   <= 4'(DATA_WAIT);
          end else begin
            state_r <= ST_INST;
            cnt_r   <= 4'(INST_WAIT);
          end
        end
        ST_DATA: begin
          if (cnt_r != 4'd0) begin
            cnt_r <= cnt_r - 4'd1;
          end else begin
            // Timer register accesses never reach the memory array.
            if (irq_hit_r) begin
              if (data_we_r) begin
                tcnt_r <= wdata_r[15:0];
                irq_r  <= 1'b0;
              end else begin
                data_in_r <= {16'd0, tcnt_r};
              end
            end else if (!data_we_r) begin
              data_in_r <= mem_r[data_idx_r];
            end else begin
              data_in_r <= data_in_r;
            end
            state_r <= ST_INST;
            cnt_r   <= 4'(INST_WAIT);
          end
        end
        ST_INST: begin
          if (cnt_r != 4'd0) begin
            cnt_r <= cnt_r - 4'd1;
          end else begin
            inst_data_r <= mem_r[inst_idx_r];
            state_r     <= ST_DONE;
          end
        end
        ST_DONE: begin
          state_r <= ST_ACCEPT;
          if (tcnt_r != 16'd0) begin
            tcnt_r <= tcnt_r - 16'd1;
            if (tcnt_r == 16'd1) begin
              irq_r <= 1'b1;
            end else begin
              irq_r <= irq_r;
            end
          end else begin
            tcnt_r <= tcnt_r;
          end
        end
        default: begin
          state_r <= ST_ACCEPT;
        end
      endcase
    end
  end

  assign halt      = (state_r != ST_DONE);
  assign irq       = irq_r;
  assign inst_data = inst_data_r;
  assign data_in   = data_in_r;

endmodule
